// File: rtl/updown_count_ctrl.sv
// Count register and run-to-target sequencer in front of an external add/subtract unit.
// Latency: a step or load shows on count one edge later; no backpressure, inputs are sampled every cycle.
module updown_count_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             sat,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_mode,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ovf,
  output logic             unf,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONES       = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   NSTEPS_MAX = {1'b1, {WIDTH{1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, target_q, step_res;
  logic [WIDTH:0]   nsteps_q;
  logic             dir_q, dir, err_q, ovf_q, unf_q;
  logic             ovf_evt, unf_evt, hit, at_rail, bound, take_step, arm;

  // The run direction is frozen at start so mid-run changes on up are ignored.
  assign dir      = (state_q == IDLE) ? up : dir_q;
  assign add_a    = count_q;
  assign add_b    = step;
  assign add_mode = ~dir;

  // For subtract the unit's carry is "no borrow", so a missing carry is an underflow.
  assign ovf_evt = dir & add_cout;
  assign unf_evt = ~dir & ~add_cout;

  always_comb begin
    step_res = add_sum;
    if (sat && ovf_evt)      step_res = ONES;
    else if (sat && unf_evt) step_res = '0;
  end

  assign hit     = (count_q == target_q);
  assign at_rail = dir_q ? (count_q == ONES) : (count_q == '0);
  assign bound   = (nsteps_q == NSTEPS_MAX) || (sat && at_rail);
  assign arm     = (state_q == IDLE) && !load && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (arm) state_d = RUN;
      RUN: begin
        if (load)              state_d = IDLE;
        else if (hit || bound) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    take_step = 1'b0;
    case (state_q)
      IDLE: take_step = !load && !start && en;
      RUN: begin
        busy      = 1'b1;
        take_step = !load && !hit && !bound;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      target_q <= '0;
      dir_q    <= 1'b0;
      nsteps_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (load)           count_q <= load_val;
      else if (take_step) count_q <= step_res;

      ovf_q <= take_step & ovf_evt;
      unf_q <= take_step & unf_evt;

      if (arm) begin
        target_q <= target;
        dir_q    <= up;
        nsteps_q <= '0;
      end else if (take_step && state_q == RUN) begin
        nsteps_q <= nsteps_q + {{WIDTH{1'b0}}, 1'b1};
      end

      // err lives only for the DONE cycle.
      if (state_q == RUN && state_d == DONE) err_q <= !hit;
      else if (state_q == DONE)              err_q <= 1'b0;
    end
  end

  assign count = count_q;
  assign err   = err_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign tc    = up ? (count_q == ONES) : (count_q == '0);

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench: the stimulus queues the expected outputs for each cycle, a negedge monitor compares them.
module tb_updown_count_ctrl;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n, load, en, up, sat, start;
  logic [W-1:0] load_val, step, target;
  logic [W-1:0] add_a, add_b, add_sum, count;
  logic         add_mode, add_cout, busy, done, err, ovf, unf, tc;
  logic [W:0]   unit_res;

  always #5 clk = ~clk;

  // Behavioural add/subtract unit: subtract is a + ~b + 1, so carry means no borrow.
  assign unit_res = add_mode ? ({1'b0, add_a} + {1'b0, ~add_b} + 6'd1)
                             : ({1'b0, add_a} + {1'b0, add_b});
  assign add_sum  = unit_res[W-1:0];
  assign add_cout = unit_res[W];

  updown_count_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en), .up(up),
    .step(step), .sat(sat), .start(start), .target(target),
    .add_a(add_a), .add_b(add_b), .add_mode(add_mode), .add_sum(add_sum), .add_cout(add_cout),
    .count(count), .busy(busy), .done(done), .err(err), .ovf(ovf), .unf(unf), .tc(tc)
  );

  typedef struct {
    int           cyc;
    string        name;
    logic [W-1:0] count;
    logic [W-1:0] stp;
    logic [6:0]   flags;  // busy,done,err,ovf,unf,tc,add_mode
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      cur = exp_q.pop_front();
      checks++;
      if (cur.cyc != cyc || count !== cur.count || add_a !== cur.count || add_b !== cur.stp ||
          {busy, done, err, ovf, unf, tc, add_mode} !== cur.flags) begin
        failures++;
        $display("FAIL %s cyc=%0d: got count=%0d add_a=%0d add_b=%0d busy,done,err,ovf,unf,tc,mode=%b; expected count=%0d add_b=%0d flags=%b (for cyc %0d)",
                 cur.name, cyc, count, add_a, add_b, {busy, done, err, ovf, unf, tc, add_mode},
                 cur.count, cur.stp, cur.flags, cur.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] c, input logic b, input logic d,
                     input logic e, input logic o, input logic u, input logic t, input logic m);
    exp_t x;
    x.cyc   = cyc;
    x.name  = nm;
    x.count = c;
    x.stp   = step;
    x.flags = {b, d, e, o, u, t, m};
    exp_q.push_back(x);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    tick();
    load     = 1'b1;
    load_val = v;
    en       = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
    step = 5'd1; sat = 1'b0; start = 1'b0; target = '0;

    tick(); chk("reset", 0, 0,0,0,0,0,0,0);
    tick(); rst_n = 1'b1; chk("reset_rel", 0, 0,0,0,0,0,0,0);

    // Up, wrap, step 1 from 30
    do_load(5'd30);
    tick(); load = 1'b0; en = 1'b1; chk("wrap_30", 30, 0,0,0,0,0,0,0);
    tick(); chk("wrap_31", 31, 0,0,0,0,0,1,0);
    tick(); en = 1'b0; chk("wrap_0", 0, 0,0,0,1,0,0,0);
    tick(); chk("wrap_hold", 0, 0,0,0,0,0,0,0);

    // Down, saturate, step 3 from 2
    do_load(5'd2);
    tick(); load = 1'b0; up = 1'b0; step = 5'd3; sat = 1'b1; en = 1'b1;
    chk("dsat_2", 2, 0,0,0,0,0,0,1);
    tick(); chk("dsat_0a", 0, 0,0,0,0,1,1,1);
    tick(); en = 1'b0; chk("dsat_0b", 0, 0,0,0,0,1,1,1);
    tick(); chk("dsat_idle", 0, 0,0,0,0,0,1,1);

    // Run to target 10 from 4 by 2; up flips low mid-run and must be ignored
    do_load(5'd4); up = 1'b1; step = 5'd2; sat = 1'b0;
    tick(); load = 1'b0; start = 1'b1; target = 5'd10; chk("run_pre", 4, 0,0,0,0,0,0,0);
    tick(); start = 1'b0; up = 1'b0; chk("run_4", 4, 1,0,0,0,0,0,0);
    tick(); chk("run_6", 6, 1,0,0,0,0,0,0);
    tick(); chk("run_8", 8, 1,0,0,0,0,0,0);
    tick(); up = 1'b1; chk("run_10", 10, 1,0,0,0,0,0,0);
    tick(); chk("run_done", 10, 1,1,0,0,0,0,0);
    tick(); chk("run_idle", 10, 0,0,0,0,0,0,0);

    // Abort a run with load 7
    tick(); start = 1'b1; target = 5'd20; chk("ab_pre", 10, 0,0,0,0,0,0,0);
    tick(); start = 1'b0; chk("ab_10", 10, 1,0,0,0,0,0,0);
    tick(); load = 1'b1; load_val = 5'd7; chk("ab_12", 12, 1,0,0,0,0,0,0);
    tick(); load = 1'b0; chk("ab_idle", 7, 0,0,0,0,0,0,0);
    tick(); chk("ab_hold", 7, 0,0,0,0,0,0,0);

    // Unreachable target 5 with step 2, wrapping: ends on the 32-step bound
    do_load(5'd0);
    tick(); load = 1'b0; start = 1'b1; target = 5'd5; chk("un_pre", 0, 0,0,0,0,0,0,0);
    for (int k = 0; k <= 32; k++) begin
      tick(); start = 1'b0;
      chk($sformatf("un_run%0d", k), W'((2 * k) % 32), 1,0,0, (k == 16 || k == 32), 0,0,0);
    end
    tick(); chk("un_done", 0, 1,1,1,0,0,0,0);
    tick(); chk("un_idle", 0, 0,0,0,0,0,0,0);

    // Same with saturation: ends at the 31 rail
    do_load(5'd0); sat = 1'b1;
    tick(); load = 1'b0; start = 1'b1; target = 5'd5; chk("us_pre", 0, 0,0,0,0,0,0,0);
    for (int k = 0; k <= 15; k++) begin
      tick(); start = 1'b0;
      chk($sformatf("us_run%0d", k), W'(2 * k), 1,0,0,0,0,0,0);
    end
    tick(); chk("us_rail", 31, 1,0,0,1,0,1,0);
    tick(); chk("us_done", 31, 1,1,1,0,0,1,0);
    tick(); chk("us_idle", 31, 0,0,0,0,0,1,0);

    // Async reset in the middle of a run
    do_load(5'd4); sat = 1'b0; step = 5'd1;
    tick(); load = 1'b0; start = 1'b1; target = 5'd20; chk("rs_pre", 4, 0,0,0,0,0,0,0);
    tick(); start = 1'b0; chk("rs_run", 4, 1,0,0,0,0,0,0);
    tick(); chk("rs_5", 5, 1,0,0,0,0,0,0);
    tick(); rst_n = 1'b0; chk("rs_async", 0, 0,0,0,0,0,0,0);
    tick(); rst_n = 1'b1; en = 1'b1; chk("rs_idle", 0, 0,0,0,0,0,0,0);
    tick(); en = 1'b0; chk("rs_step", 1, 0,0,0,0,0,0,0);

    // Zero step in IDLE leaves count alone
    tick(); step = 5'd0; en = 1'b1; chk("z_pre", 1, 0,0,0,0,0,0,0);
    tick(); en = 1'b0; chk("z_hold", 1, 0,0,0,0,0,0,0);

    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
